// File: rtl/fifo_pool_param_if.sv
// Handshake bundle between a producer/consumer and fifo_pool_param.
// The master side drives writes, reads and flush; the slave side is the buffer.
interface fifo_pool_param_if #(
    parameter int DATA_W  = 32,
    parameter int BACK_AW = 14
);
    logic                 flush;
    logic                 wr_en;
    logic [DATA_W-1:0]    wr_data;
    logic                 wr_full;
    logic                 wr_almost_full;
    logic                 rd_en;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_empty;
    logic                 rd_almost_empty;
    logic [BACK_AW+1:0]   level;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output flush,
        output wr_en,
        output wr_data,
        output rd_en,
        input  wr_full,
        input  wr_almost_full,
        input  rd_data,
        input  rd_empty,
        input  rd_almost_empty,
        input  level,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  flush,
        input  wr_en,
        input  wr_data,
        input  rd_en,
        output wr_full,
        output wr_almost_full,
        output rd_data,
        output rd_empty,
        output rd_almost_empty,
        output level,
        output overflow,
        output underflow
    );
endinterface

// File: rtl/fifo_pool_param.sv
// Two-stage elastic buffer: a small distributed-RAM ingress FIFO feeding a
// block-RAM bulk FIFO through a one-word-per-cycle mover, with hold-off and flush.
module fifo_pool_param #(
    parameter int DATA_W      = 32,
    parameter int FRONT_AW    = 12,
    parameter int BACK_AW     = 14,  // must be >= FRONT_AW
    parameter int AF_MARGIN   = 16,
    parameter int AE_MARGIN   = 4,
    parameter int HOLD_CYCLES = 16   // must be >= 1
) (
    input  logic             clk,
    input  logic             rst,
    fifo_pool_param_if.slave bus
);
    localparam int FD = 32'd1 << FRONT_AW;
    localparam int BD = 32'd1 << BACK_AW;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int LW = BACK_AW + 2;

    localparam logic [FRONT_AW:0] F_ZERO = {(FRONT_AW+1){1'b0}};
    localparam logic [FRONT_AW:0] F_ONE  = {{FRONT_AW{1'b0}}, 1'b1};
    localparam logic [FRONT_AW:0] FD_C   = (FRONT_AW+1)'(FD);
    localparam logic [FRONT_AW:0] AF_C   = (FRONT_AW+1)'(FD - AF_MARGIN);
    localparam logic [BACK_AW:0]  B_ZERO = {(BACK_AW+1){1'b0}};
    localparam logic [BACK_AW:0]  B_ONE  = {{BACK_AW{1'b0}}, 1'b1};
    localparam logic [BACK_AW:0]  BD_C   = (BACK_AW+1)'(BD);
    localparam logic [BACK_AW:0]  AE_C   = (BACK_AW+1)'(AE_MARGIN);
    localparam logic [HW-1:0]     H_ZERO = {HW{1'b0}};
    localparam logic [HW-1:0]     H_ONE  = {{(HW-1){1'b0}}, 1'b1};
    localparam logic [HW-1:0]     HOLD_C = HW'(HOLD_CYCLES);
    localparam logic [FRONT_AW-1:0] FP_ONE = {{(FRONT_AW-1){1'b0}}, 1'b1};
    localparam logic [BACK_AW-1:0]  BP_ONE = {{(BACK_AW-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0]   front_mem_r [FD];
    logic [DATA_W-1:0]   back_mem_r  [BD];

    logic [FRONT_AW-1:0] f_wptr_r;
    logic [FRONT_AW-1:0] f_rptr_r;
    logic [FRONT_AW:0]   f_count_r;
    logic [BACK_AW-1:0]  b_wptr_r;
    logic [BACK_AW-1:0]  b_rptr_r;
    logic [BACK_AW:0]    b_count_r;
    logic [HW-1:0]       hold_r;

    logic                wr_full_r;
    logic                wr_almost_full_r;
    logic                rd_empty_r;
    logic                rd_almost_empty_r;
    logic [LW-1:0]       level_r;
    logic                overflow_r;
    logic                underflow_r;
    logic [DATA_W-1:0]   rd_data_r;

    logic                hold_active_s;
    logic                wr_fire_s;
    logic                wr_drop_s;
    logic                rd_fire_s;
    logic                rd_drop_s;
    logic                move_s;
    logic [HW-1:0]       hold_nxt_s;
    logic [FRONT_AW:0]   f_count_nxt_s;
    logic [BACK_AW:0]    b_count_nxt_s;
    logic                overflow_nxt_s;
    logic                underflow_nxt_s;

    // Qualify requests against registered flags; flush masks every action.
    always_comb begin
        hold_active_s = (hold_r != H_ZERO);
        wr_fire_s     = bus.wr_en & ~wr_full_r  & ~bus.flush;
        wr_drop_s     = bus.wr_en &  wr_full_r  & ~bus.flush;
        rd_fire_s     = bus.rd_en & ~rd_empty_r & ~bus.flush;
        rd_drop_s     = bus.rd_en &  rd_empty_r & ~bus.flush;
        move_s        = ~bus.flush & ~hold_active_s &
                        (f_count_r != F_ZERO) & (b_count_r != BD_C);
    end

    // Hold-off counter next state: reload on flush, count down to zero.
    always_comb begin
        if (bus.flush) begin
            hold_nxt_s = HOLD_C;
        end else if (hold_active_s) begin
            hold_nxt_s = hold_r - H_ONE;
        end else begin
            hold_nxt_s = hold_r;
        end
    end

    // Front occupancy: a write and a move in the same cycle cancel.
    always_comb begin
        f_count_nxt_s = f_count_r;
        if (bus.flush) begin
            f_count_nxt_s = F_ZERO;
        end else begin
            case ({wr_fire_s, move_s})
                2'b10:   f_count_nxt_s = f_count_r + F_ONE;
                2'b01:   f_count_nxt_s = f_count_r - F_ONE;
                default: f_count_nxt_s = f_count_r;
            endcase
        end
    end

    // Back occupancy: a move and a read in the same cycle cancel.
    always_comb begin
        b_count_nxt_s = b_count_r;
        if (bus.flush) begin
            b_count_nxt_s = B_ZERO;
        end else begin
            case ({move_s, rd_fire_s})
                2'b10:   b_count_nxt_s = b_count_r + B_ONE;
                2'b01:   b_count_nxt_s = b_count_r - B_ONE;
                default: b_count_nxt_s = b_count_r;
            endcase
        end
    end

    // Sticky error flags next state.
    always_comb begin
        if (bus.flush) begin
            overflow_nxt_s  = 1'b0;
            underflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s  = overflow_r  | wr_drop_s;
            underflow_nxt_s = underflow_r | rd_drop_s;
        end
    end

    // Pointers, counts and hold-off state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_wptr_r  <= {FRONT_AW{1'b0}};
            f_rptr_r  <= {FRONT_AW{1'b0}};
            b_wptr_r  <= {BACK_AW{1'b0}};
            b_rptr_r  <= {BACK_AW{1'b0}};
            f_count_r <= F_ZERO;
            b_count_r <= B_ZERO;
            hold_r    <= HOLD_C;
        end else if (bus.flush) begin
            f_wptr_r  <= {FRONT_AW{1'b0}};
            f_rptr_r  <= {FRONT_AW{1'b0}};
            b_wptr_r  <= {BACK_AW{1'b0}};
            b_rptr_r  <= {BACK_AW{1'b0}};
            f_count_r <= F_ZERO;
            b_count_r <= B_ZERO;
            hold_r    <= HOLD_C;
        end else begin
            if (wr_fire_s) f_wptr_r <= f_wptr_r + FP_ONE;
            if (move_s) begin
                f_rptr_r <= f_rptr_r + FP_ONE;
                b_wptr_r <= b_wptr_r + BP_ONE;
            end
            if (rd_fire_s) b_rptr_r <= b_rptr_r + BP_ONE;
            f_count_r <= f_count_nxt_s;
            b_count_r <= b_count_nxt_s;
            hold_r    <= hold_nxt_s;
        end
    end

    // Status outputs registered from next-state counts so they line up with the counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_full_r         <= 1'b1;
            wr_almost_full_r  <= 1'b1;
            rd_empty_r        <= 1'b1;
            rd_almost_empty_r <= 1'b1;
            level_r           <= {LW{1'b0}};
            overflow_r        <= 1'b0;
            underflow_r       <= 1'b0;
        end else begin
            wr_full_r         <= (hold_nxt_s != H_ZERO) | (f_count_nxt_s == FD_C);
            wr_almost_full_r  <= (hold_nxt_s != H_ZERO) | (f_count_nxt_s >= AF_C);
            rd_empty_r        <= (b_count_nxt_s == B_ZERO);
            rd_almost_empty_r <= (b_count_nxt_s <= AE_C);
            level_r           <= LW'(f_count_nxt_s) + LW'(b_count_nxt_s);
            overflow_r        <= overflow_nxt_s;
            underflow_r       <= underflow_nxt_s;
        end
    end

    // Ingress storage: distributed RAM, read asynchronously by the mover.
    always_ff @(posedge clk) begin
        if (wr_fire_s) front_mem_r[f_wptr_r] <= bus.wr_data;
    end

    // Bulk storage: written by the mover only.
    always_ff @(posedge clk) begin
        if (move_s) back_mem_r[b_wptr_r] <= front_mem_r[f_rptr_r];
    end

    // Synchronous bulk read; rd_data holds across empty reads and flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else if (rd_fire_s) begin
            rd_data_r <= back_mem_r[b_rptr_r];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign bus.wr_full         = wr_full_r;
    assign bus.wr_almost_full  = wr_almost_full_r;
    assign bus.rd_empty        = rd_empty_r;
    assign bus.rd_almost_empty = rd_almost_empty_r;
    assign bus.level           = level_r;
    assign bus.overflow        = overflow_r;
    assign bus.underflow       = underflow_r;
    assign bus.rd_data         = rd_data_r;
endmodule

// File: tb/tb_fifo_pool_param.sv
// Directed bench for fifo_pool_param with FD=4, BD=8, margins 1, hold-off 4.
module tb_fifo_pool_param;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fifo_pool_param_if #(.DATA_W(32), .BACK_AW(3)) bus ();

    fifo_pool_param #(
        .DATA_W(32), .FRONT_AW(2), .BACK_AW(3),
        .AF_MARGIN(1), .AE_MARGIN(1), .HOLD_CYCLES(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.wr_data = 32'h0;
        step();
        check("rst_wr_full", 32'(bus.wr_full), 32'd1);
        check("rst_wr_af", 32'(bus.wr_almost_full), 32'd1);
        check("rst_rd_empty", 32'(bus.rd_empty), 32'd1);
        check("rst_rd_ae", 32'(bus.rd_almost_empty), 32'd1);
        check("rst_rd_data", bus.rd_data, 32'h0);
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_unf", 32'(bus.underflow), 32'd0);

        // Hold-off: writes dropped on E0..E3, accepted on E4.
        rst = 1'b0;
        bus.wr_en = 1'b1;
        bus.wr_data = 32'hA0;
        step();
        check("hold_ovf", 32'(bus.overflow), 32'd1);
        check("hold_full_e0", 32'(bus.wr_full), 32'd1);
        step();
        step();
        check("hold_full_e2", 32'(bus.wr_full), 32'd1);
        step();
        check("hold_full_e3", 32'(bus.wr_full), 32'd0);
        check("hold_af_e3", 32'(bus.wr_almost_full), 32'd0);
        check("hold_level_e3", 32'(bus.level), 32'd0);
        step();
        bus.wr_en = 1'b0;
        check("hold_level_e4", 32'(bus.level), 32'd1);
        check("hold_empty_e4", 32'(bus.rd_empty), 32'd1);
        step();
        check("hold_empty_e5", 32'(bus.rd_empty), 32'd0);

        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush1_ovf", 32'(bus.overflow), 32'd0);
        check("flush1_level", 32'(bus.level), 32'd0);
        repeat (4) step();

        // Ordering: 12 writes fill back (8) and front (4).
        for (int k = 1; k <= 12; k++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 32'(k);
            step();
        end
        bus.wr_en = 1'b0;
        check("ord_level", 32'(bus.level), 32'd12);
        check("ord_full", 32'(bus.wr_full), 32'd1);
        check("ord_ovf", 32'(bus.overflow), 32'd0);
        bus.rd_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("ord_rd", bus.rd_data, 32'(k));
        end
        bus.rd_en = 1'b0;
        check("ord_empty", 32'(bus.rd_empty), 32'd1);
        check("ord_level0", 32'(bus.level), 32'd0);

        // Underflow: read from empty keeps rd_data.
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        check("unf_flag", 32'(bus.underflow), 32'd1);
        check("unf_data", bus.rd_data, 32'h0C);

        // Watermarks: back full, front 3 then 4, then overflow.
        for (int k = 0; k < 11; k++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 32'h21 + 32'(k);
            step();
        end
        bus.wr_en = 1'b0;
        check("wm_level11", 32'(bus.level), 32'd11);
        check("wm_af", 32'(bus.wr_almost_full), 32'd1);
        check("wm_full0", 32'(bus.wr_full), 32'd0);
        check("wm_ae0", 32'(bus.rd_almost_empty), 32'd0);
        bus.wr_en = 1'b1;
        bus.wr_data = 32'h2C;
        step();
        check("wm_full1", 32'(bus.wr_full), 32'd1);
        bus.wr_data = 32'hEE;
        step();
        bus.wr_en = 1'b0;
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        check("ovf_level", 32'(bus.level), 32'd12);
        bus.rd_en = 1'b1;
        repeat (11) step();
        bus.rd_en = 1'b0;
        check("wm_drain_data", bus.rd_data, 32'h2B);
        check("wm_drain_level", 32'(bus.level), 32'd1);
        check("wm_ae1", 32'(bus.rd_almost_empty), 32'd1);
        check("wm_not_empty", 32'(bus.rd_empty), 32'd0);
        check("sticky_ovf", 32'(bus.overflow), 32'd1);
        check("sticky_unf", 32'(bus.underflow), 32'd1);

        // Flush mid-stream at level 7 with concurrent requests.
        for (int k = 0; k < 6; k++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 32'h31 + 32'(k);
            step();
        end
        check("fl_level7", 32'(bus.level), 32'd7);
        bus.flush = 1'b1;
        bus.wr_data = 32'h99;
        bus.rd_en = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check("fl_level", 32'(bus.level), 32'd0);
        check("fl_empty", 32'(bus.rd_empty), 32'd1);
        check("fl_ovf", 32'(bus.overflow), 32'd0);
        check("fl_unf", 32'(bus.underflow), 32'd0);
        check("fl_full", 32'(bus.wr_full), 32'd1);
        check("fl_rd_data", bus.rd_data, 32'h2B);
        for (int k = 0; k < 3; k++) begin
            step();
            check("fl_hold_full", 32'(bus.wr_full), 32'd1);
        end
        step();
        check("fl_release", 32'(bus.wr_full), 32'd0);
        bus.wr_en = 1'b1;
        bus.wr_data = 32'h55;
        step();
        bus.wr_en = 1'b0;
        check("fl_new_empty", 32'(bus.rd_empty), 32'd1);
        step();
        check("fl_new_avail", 32'(bus.rd_empty), 32'd0);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        check("fl_new_data", bus.rd_data, 32'h55);
        check("fl_new_drained", 32'(bus.rd_empty), 32'd1);

        // Concurrency at boundary: back 8, front 2, then 20 cycles of read+write.
        for (int k = 0; k < 10; k++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 32'h61 + 32'(k);
            step();
        end
        check("cc_level_start", 32'(bus.level), 32'd10);
        for (int k = 0; k < 20; k++) begin
            bus.wr_en = 1'b1;
            bus.rd_en = 1'b1;
            bus.wr_data = 32'h6B + 32'(k);
            step();
            check("cc_rd", bus.rd_data, 32'h61 + 32'(k));
            check("cc_level", 32'(bus.level), 32'd10);
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check("cc_ovf", 32'(bus.overflow), 32'd0);
        check("cc_unf", 32'(bus.underflow), 32'd0);

        // Asynchronous reset between edges.
        #3;
        rst = 1'b1;
        #1;
        check("arst_full", 32'(bus.wr_full), 32'd1);
        check("arst_level", 32'(bus.level), 32'd0);
        check("arst_data", bus.rd_data, 32'h0);
        check("arst_empty", 32'(bus.rd_empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
